// File: rtl/imem_loader_if.sv
// imem_loader_if
// Groups the loader's byte-stream handshake and its instruction-memory write port.
//   in_valid : byte source has a byte on in_data
//   in_data  : stream byte (8 bits)
//   in_ready : loader accepts a byte this cycle
//   wr_en    : one-cycle instruction memory write strobe
//   wr_addr  : word-aligned byte address of the write (ADDR_W bits)
//   wr_data  : instruction word (32 bits)
// Modports:
//   master : environment side (drives the stream, observes the write port)
//   slave  : loader side
// ADDR_W must match the ADDR_W of the attached imem_loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time program loader. Receives a byte stream (16-bit big-endian word count N followed
// by 4*N bytes), assembles big-endian 32-bit words and writes word k to byte address 4*k of
// instruction memory. The processor is held in reset until the whole image is written.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   start     : single-cycle pulse, begins a load from IDLE, DONE or ERROR (ignored while busy)
//   bus       : imem_loader_if.slave - byte stream in, memory write port out
//   cpu_reset : holds the processor in reset; low only once the image is complete
//   busy      : load in progress
//   done      : image fully written (level)
//   error     : header word count exceeded DEPTH (level)
module imem_loader #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StFlush,
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [15:0]       len_q, len_d;
    logic [23:0]       word_q, word_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic              in_ready_c;
    logic              xfer;
    logic [15:0]       len_full;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        in_ready_c = 1'b0;
        busy       = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;

        unique case (state_q)
            StLenHi, StLenLo, StData: begin
                in_ready_c = 1'b1;
                busy       = 1'b1;
            end
            StFlush: busy = 1'b1;
            StDone: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            StError: error = 1'b1;
            default: ;
        endcase

        xfer     = bus.in_valid && in_ready_c;
        len_full = {len_q[15:8], bus.in_data};

        unique case (state_q)
            StIdle, StDone, StError: begin
                // done/error are decoded from state, so leaving DONE/ERROR clears them
                if (start) begin
                    state_d    = StLenHi;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 16'd0;
                    wr_addr_d  = '0;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[15:8] = bus.in_data;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d[7:0] = bus.in_data;
                    if (len_full == 16'd0) begin
                        state_d = StDone;
                    end else if (32'(len_full) > DEPTH) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    word_d     = {word_q[15:0], bus.in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = ADDR_W'({word_cnt_q, 2'b00});
                        wr_data_d  = {word_q, bus.in_data};
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_d == len_q) begin
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 16'd0;
            len_q      <= 16'd0;
            word_q     <= 24'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            word_q     <= word_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader: continuous and stalled loads, N=0 / N=DEPTH / N=DEPTH+1,
// reset mid-word, restart from DONE/ERROR, start ignored while busy.
module tb_imem_loader;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 32;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset;
    logic busy;
    logic done;
    logic error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus.slave),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int tmo_cnt  = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  img[$];

    // Write log, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    // Present a byte and hold it until it is accepted on a clock edge
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) tmo_cnt++;
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Send img; with stall, in_valid toggles every cycle plus a 7-cycle gap inside word 0
    task automatic send_image(input bit stall);
        for (int i = 0; i < img.size(); i++) begin
            if (stall) idle(1);
            if (stall && i == 4) idle(7);
            send_byte(img[i]);
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] exp_word(input int k);
        logic [7:0] kb;
        kb = k[7:0];
        return {8'hA5, kb, ~kb, 8'h3C};
    endfunction

    initial begin
        int bad;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        tick();
        tick();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        tick();

        // reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_wins_busy", busy, 0);
        tick();
        check("rst_wins_ready", bus.in_ready, 0);

        // Two-word load, one byte per clock
        clear_log();
        pulse_start();
        check("t2_busy", busy, 1);
        check("t2_in_ready", bus.in_ready, 1);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        check("t2_w0_en", bus.wr_en, 1);
        check("t2_w0_addr", bus.wr_addr, 32'h0);
        check("t2_w0_data", bus.wr_data, 32'h20080005);
        send_byte(8'hAC);
        check("t2_w0_one_cycle", bus.wr_en, 0);
        send_byte(8'h09); send_byte(8'h00); send_byte(8'h04);
        bus.in_valid = 1'b0;
        check("t2_w1_en", bus.wr_en, 1);
        check("t2_w1_addr", bus.wr_addr, 32'h4);
        check("t2_w1_data", bus.wr_data, 32'hAC090004);
        check("t2_not_done_yet", done, 0);
        check("t2_cpu_held", cpu_reset, 1);
        tick();
        check("t2_w1_one_cycle", bus.wr_en, 0);
        check("t2_done", done, 1);
        check("t2_cpu_release", cpu_reset, 0);
        check("t2_idle_busy", busy, 0);
        check("t2_nwrites", wa.size(), 2);

        // Stalled stream, restart from DONE
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};
        clear_log();
        pulse_start();
        check("t3_done_clr", done, 0);
        check("t3_cpu_reset", cpu_reset, 1);
        send_image(1'b1);
        tick();
        tick();
        check("t3_nwrites", wa.size(), 2);
        check("t3_a0", wa[0], 32'h0);
        check("t3_d0", wd[0], 32'h20080005);
        check("t3_a1", wa[1], 32'h4);
        check("t3_d1", wd[1], 32'hAC090004);
        check("t3_done", done, 1);

        // N = 0
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        bus.in_valid = 1'b0;
        check("n0_done", done, 1);
        check("n0_cpu", cpu_reset, 0);
        check("n0_busy", busy, 0);
        tick();
        check("n0_nwrites", wa.size(), 0);

        // N = DEPTH
        img = '{8'h01, 8'h00};
        for (int k = 0; k < 256; k++) begin
            logic [31:0] w;
            w = exp_word(k);
            img.push_back(w[31:24]);
            img.push_back(w[23:16]);
            img.push_back(w[15:8]);
            img.push_back(w[7:0]);
        end
        clear_log();
        pulse_start();
        send_image(1'b0);
        tick();
        tick();
        check("nmax_nwrites", wa.size(), 256);
        check("nmax_last_addr", wa[255], 32'h3FC);
        check("nmax_last_data", wd[255], 32'hA5FF003C);
        bad = 0;
        for (int k = 0; k < wa.size(); k++) begin
            if (wa[k] !== 32'(4 * k) || wd[k] !== exp_word(k)) bad++;
        end
        check("nmax_bad_words", bad, 0);
        check("nmax_done", done, 1);

        // N = DEPTH + 1
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check("nover_error", error, 1);
        check("nover_cpu", cpu_reset, 1);
        check("nover_ready", bus.in_ready, 0);
        check("nover_done", done, 0);
        check("nover_busy", busy, 0);
        bus.in_data = 8'h55;
        for (int i = 0; i < 5; i++) tick();
        bus.in_valid = 1'b0;
        check("nover_nwrites", wa.size(), 0);

        // Restart from ERROR, reset after 2 bytes of word index 2
        img = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                8'h99, 8'hAA, 8'hBB, 8'hCC};
        clear_log();
        pulse_start();
        check("rerr_error_clr", error, 0);
        check("rerr_busy", busy, 1);
        for (int i = 0; i < 12; i++) send_byte(img[i]);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cpu", cpu_reset, 1);
        check("mid_rst_ready", bus.in_ready, 0);
        check("mid_rst_wr_addr", bus.wr_addr, 0);
        check("mid_rst_wr_data", bus.wr_data, 0);
        check("mid_rst_done", done, 0);
        tick();
        tick();
        check("mid_rst_nwrites", wa.size(), 2);
        check("mid_rst_a1", wa[1], 32'h4);
        check("mid_rst_d1", wd[1], 32'h55667788);

        img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_log();
        pulse_start();
        send_image(1'b0);
        tick();
        tick();
        check("fresh_nwrites", wa.size(), 1);
        check("fresh_a0", wa[0], 32'h0);
        check("fresh_d0", wd[0], 32'hDEADBEEF);
        check("fresh_done", done, 1);

        // start while busy is ignored
        img = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0B, 8'hAD, 8'hC0, 8'hDE};
        clear_log();
        pulse_start();
        check("rdone_done_clr", done, 0);
        check("rdone_cpu", cpu_reset, 1);
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        start = 1'b1;
        send_byte(img[4]);
        start = 1'b0;
        for (int i = 5; i < img.size(); i++) send_byte(img[i]);
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("sbusy_nwrites", wa.size(), 2);
        check("sbusy_d0", wd[0], 32'hCAFEF00D);
        check("sbusy_a1", wa[1], 32'h4);
        check("sbusy_d1", wd[1], 32'h0BADC0DE);
        check("sbusy_done", done, 1);

        check("no_timeouts", tmo_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
